// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module : branch_resolve_queue
// Brief  : In-flight branch queue; emits history-table updates and redirects.
// Rev    : 1.0
// ============================================================================
module branch_resolve_queue #(
   parameter int PC_W  = 32,
   parameter int LOWER = 7,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              push_valid,
   input  logic [PC_W-1:0]   push_pc,
   input  logic              push_pred,
   output logic              full,
   output logic              empty,
   input  logic              res_valid,
   input  logic              res_taken,
   input  logic              res_jump,
   input  logic [PC_W-1:0]   res_target,
   input  logic              ext_flush,
   output logic              upd_valid,
   output logic [LOWER-1:0]  upd_addr,
   output logic              upd_was_taken,
   output logic              upd_jumped,
   output logic              mispredict,
   output logic [PC_W-1:0]   redirect_pc,
   output logic              underflow_err,
   output logic [CNT_W-1:0]  mispred_cnt,
   output logic [CNT_W-1:0]  resolve_cnt
);

   localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cnt_w = c_ptr_w + 1;

   logic [PC_W-1:0]    r_pc_mem   [DEPTH];
   logic               r_pred_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;

   logic               r_upd_valid;
   logic [LOWER-1:0]   r_upd_addr;
   logic               r_upd_was_taken;
   logic               r_upd_jumped;
   logic               r_mispredict;
   logic [PC_W-1:0]    r_redirect_pc;
   logic               r_underflow_err;
   logic [CNT_W-1:0]   r_mispred_cnt;
   logic [CNT_W-1:0]   r_resolve_cnt;

   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_push;
   logic               w_actual;
   logic               w_mis;
   logic               w_flush;
   logic [PC_W-1:0]    w_head_pc;
   logic               w_head_pred;
   logic [PC_W-1:0]    w_fall_pc;
   logic [PC_W-1:0]    w_redirect;

   assign w_full      = (r_count == c_cnt_w'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_head_pc   = r_pc_mem[r_rd_ptr];
   assign w_head_pred = r_pred_mem[r_rd_ptr];
   assign w_pop       = res_valid && !w_empty;
   assign w_actual    = res_taken | res_jump;
   assign w_mis       = w_pop && (w_actual != w_head_pred);
   // A mispredict discards the wrong-path younger entries, including any same-cycle push.
   assign w_flush     = w_mis || ext_flush;
   assign w_push      = push_valid && (!w_full || w_pop) && !w_flush;
   assign w_fall_pc   = w_head_pc + PC_W'(4);
   assign w_redirect  = w_actual ? res_target : w_fall_pc;

   // Entry storage carries no reset: validity is tracked solely by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= push_pc;
         r_pred_mem[r_wr_ptr] <= push_pred;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_upd_valid     <= 1'b0;
         r_upd_addr      <= '0;
         r_upd_was_taken <= 1'b0;
         r_upd_jumped    <= 1'b0;
         r_mispredict    <= 1'b0;
         r_redirect_pc   <= '0;
         r_underflow_err <= 1'b0;
         r_mispred_cnt   <= '0;
         r_resolve_cnt   <= '0;
      end else begin
         r_upd_valid  <= w_pop;
         r_mispredict <= w_mis;
         if (w_pop) begin
            r_upd_addr      <= w_head_pc[LOWER-1:0];
            r_upd_was_taken <= res_taken;
            r_upd_jumped    <= res_jump;
            if (!(&r_resolve_cnt)) begin
               r_resolve_cnt <= r_resolve_cnt + CNT_W'(1);
            end
         end
         if (w_mis) begin
            r_redirect_pc <= w_redirect;
            if (!(&r_mispred_cnt)) begin
               r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
         end
         if (res_valid && w_empty) begin
            r_underflow_err <= 1'b1;
         end
      end
   end

   assign full          = w_full;
   assign empty         = w_empty;
   assign upd_valid     = r_upd_valid;
   assign upd_addr      = r_upd_addr;
   assign upd_was_taken = r_upd_was_taken;
   assign upd_jumped    = r_upd_jumped;
   assign mispredict    = r_mispredict;
   assign redirect_pc   = r_redirect_pc;
   assign underflow_err = r_underflow_err;
   assign mispred_cnt   = r_mispred_cnt;
   assign resolve_cnt   = r_resolve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_resolve_queue
// Brief  : Directed stimulus, queue-based reference model and literal checks.
// Rev    : 1.0
// ============================================================================
module tb_branch_resolve_queue;

   localparam int PC_W  = 32;
   localparam int LOWER = 7;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] c_sat = '1;

   logic             clk = 1'b0;
   logic             arst_n;
   logic             push_valid, push_pred;
   logic [PC_W-1:0]  push_pc;
   logic             full, empty;
   logic             res_valid, res_taken, res_jump;
   logic [PC_W-1:0]  res_target;
   logic             ext_flush;
   logic             upd_valid, upd_was_taken, upd_jumped, mispredict, underflow_err;
   logic [LOWER-1:0] upd_addr;
   logic [PC_W-1:0]  redirect_pc;
   logic [CNT_W-1:0] mispred_cnt, resolve_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   branch_resolve_queue #(.PC_W(PC_W), .LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .arst_n(arst_n),
      .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred),
      .full(full), .empty(empty),
      .res_valid(res_valid), .res_taken(res_taken), .res_jump(res_jump),
      .res_target(res_target), .ext_flush(ext_flush),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_was_taken(upd_was_taken),
      .upd_jumped(upd_jumped), .mispredict(mispredict), .redirect_pc(redirect_pc),
      .underflow_err(underflow_err), .mispred_cnt(mispred_cnt), .resolve_cnt(resolve_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: queue of {pc, pred}, outputs derived straight from the rules.
   logic [PC_W:0]    mq[$];
   logic [PC_W:0]    m_e;
   logic             m_act;
   logic             m_upd_valid, m_taken, m_jumped, m_mis, m_uf;
   logic [LOWER-1:0] m_addr;
   logic [PC_W-1:0]  m_redir;
   logic [CNT_W-1:0] m_mcnt, m_rcnt;

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         mq.delete();
         m_upd_valid = 0; m_taken = 0; m_jumped = 0; m_mis = 0; m_uf = 0;
         m_addr = '0; m_redir = '0; m_mcnt = '0; m_rcnt = '0;
      end else begin
         m_upd_valid = 0;
         m_mis       = 0;
         if (res_valid && mq.size() == 0) m_uf = 1;
         if (res_valid && mq.size() != 0) begin
            m_e         = mq.pop_front();
            m_act       = res_taken | res_jump;
            m_upd_valid = 1;
            m_addr      = m_e[LOWER:1];
            m_taken     = res_taken;
            m_jumped    = res_jump;
            if (m_rcnt != c_sat) m_rcnt = m_rcnt + 1'b1;
            if (m_act != m_e[0]) begin
               m_mis   = 1;
               m_redir = m_act ? res_target : (m_e[PC_W:1] + 32'd4);
               if (m_mcnt != c_sat) m_mcnt = m_mcnt + 1'b1;
            end
         end
         if (m_mis || ext_flush) mq.delete();
         else if (push_valid && mq.size() < DEPTH) mq.push_back({push_pc, push_pred});
      end
   end

   always @(negedge clk) begin
      if (arst_n) begin
         check("full",          32'(full),          32'(mq.size() == DEPTH));
         check("empty",         32'(empty),         32'(mq.size() == 0));
         check("upd_valid",     32'(upd_valid),     32'(m_upd_valid));
         check("upd_addr",      32'(upd_addr),      32'(m_addr));
         check("upd_was_taken", 32'(upd_was_taken), 32'(m_taken));
         check("upd_jumped",    32'(upd_jumped),    32'(m_jumped));
         check("mispredict",    32'(mispredict),    32'(m_mis));
         check("redirect_pc",   redirect_pc,        m_redir);
         check("underflow_err", 32'(underflow_err), 32'(m_uf));
         check("mispred_cnt",   32'(mispred_cnt),   32'(m_mcnt));
         check("resolve_cnt",   32'(resolve_cnt),   32'(m_rcnt));
      end
   end

   // Drive one cycle of inputs starting just after a rising edge.
   task automatic cyc(input logic pv, input logic [31:0] pc, input logic pr,
                      input logic rv, input logic rt, input logic rj,
                      input logic [31:0] tg, input logic fl);
      push_valid = pv; push_pc = pc; push_pred = pr;
      res_valid = rv; res_taken = rt; res_jump = rj; res_target = tg; ext_flush = fl;
      @(posedge clk); #1;
      push_valid = 0; res_valid = 0; res_taken = 0; res_jump = 0; ext_flush = 0;
   endtask

   task automatic push(input logic [31:0] pc, input logic pr);
      cyc(1'b1, pc, pr, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic pop(input logic t, input logic j, input logic [31:0] tg);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, t, j, tg, 1'b0);
   endtask

   task automatic reset_pulse();
      arst_n = 0;
      @(posedge clk); #1;
      arst_n = 1;
   endtask

   initial begin
      push_valid = 0; push_pc = '0; push_pred = 0;
      res_valid = 0; res_taken = 0; res_jump = 0; res_target = '0; ext_flush = 0;
      arst_n = 0;
      repeat (2) @(posedge clk);
      #1 arst_n = 1;
      check("rst_upd_valid", 32'(upd_valid), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_redirect", redirect_pc, 32'd0);
      check("rst_underflow", 32'(underflow_err), 32'd0);

      // Mispredicted not-taken branch
      push(32'h40, 1'b0);
      pop(1'b1, 1'b0, 32'h80);
      check("t1_upd_valid", 32'(upd_valid), 32'd1);
      check("t1_upd_addr", 32'(upd_addr), 32'h40);
      check("t1_taken", 32'(upd_was_taken), 32'd1);
      check("t1_mispredict", 32'(mispredict), 32'd1);
      check("t1_redirect", redirect_pc, 32'h80);
      check("t1_empty", 32'(empty), 32'd1);
      check("t1_mcnt", 32'(mispred_cnt), 32'd1);

      // Fill, overflow drop, in-order drain
      reset_pulse();
      push(32'h10, 1'b1); push(32'h14, 1'b1); push(32'h18, 1'b1); push(32'h1C, 1'b1);
      check("t2_full", 32'(full), 32'd1);
      push(32'h20, 1'b1);
      check("t2_full_after_drop", 32'(full), 32'd1);
      pop(1'b1, 1'b0, 32'h0); check("t2_addr0", 32'(upd_addr), 32'h10);
      pop(1'b1, 1'b0, 32'h0); check("t2_addr1", 32'(upd_addr), 32'h14);
      pop(1'b1, 1'b0, 32'h0); check("t2_addr2", 32'(upd_addr), 32'h18);
      pop(1'b1, 1'b0, 32'h0); check("t2_addr3", 32'(upd_addr), 32'h1C);
      check("t2_nomis", 32'(mispredict), 32'd0);
      check("t2_rcnt", 32'(resolve_cnt), 32'd4);
      check("t2_empty", 32'(empty), 32'd1);

      // Push+pop while full
      reset_pulse();
      push(32'h100, 1'b1); push(32'h104, 1'b1); push(32'h108, 1'b1); push(32'h10C, 1'b1);
      cyc(1'b1, 32'h110, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("t3_full", 32'(full), 32'd1);
      check("t3_addr", 32'(upd_addr), 32'h00);
      repeat (4) pop(1'b1, 1'b0, 32'h0);
      check("t3_last_addr", 32'(upd_addr), 32'h10);
      check("t3_empty", 32'(empty), 32'd1);

      // Predicted-taken resolves not-taken with wrong-path push
      reset_pulse();
      push(32'h20, 1'b1); push(32'h28, 1'b1); push(32'h2C, 1'b1);
      cyc(1'b1, 32'h50, 1'b1, 1'b1, 1'b0, 1'b0, 32'h999, 1'b0);
      check("t4_mispredict", 32'(mispredict), 32'd1);
      check("t4_redirect", redirect_pc, 32'h24);
      check("t4_empty", 32'(empty), 32'd1);

      // External flush with same-cycle pop and push
      push(32'h60, 1'b1); push(32'h64, 1'b1);
      cyc(1'b1, 32'h68, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check("t5_upd_valid", 32'(upd_valid), 32'd1);
      check("t5_upd_addr", 32'(upd_addr), 32'h60);
      check("t5_empty", 32'(empty), 32'd1);

      // Underflow is sticky until reset
      pop(1'b1, 1'b0, 32'h0);
      check("t6_no_upd", 32'(upd_valid), 32'd0);
      check("t6_underflow", 32'(underflow_err), 32'd1);
      push(32'h70, 1'b1); pop(1'b1, 1'b0, 32'h0);
      check("t6_sticky", 32'(underflow_err), 32'd1);
      reset_pulse();
      check("t6_cleared", 32'(underflow_err), 32'd0);

      // Jump mispredict, then asynchronous reset mid-queue
      push(32'h30, 1'b0); push(32'h34, 1'b0);
      pop(1'b0, 1'b1, 32'h0);
      check("t7_jumped", 32'(upd_jumped), 32'd1);
      check("t7_mispredict", 32'(mispredict), 32'd1);
      check("t7_redirect", redirect_pc, 32'h0);
      check("t7_empty", 32'(empty), 32'd1);
      push(32'h80, 1'b1); push(32'h84, 1'b1);
      #2 arst_n = 0;
      #1;
      check("t7_rst_addr", 32'(upd_addr), 32'd0);
      check("t7_rst_jumped", 32'(upd_jumped), 32'd0);
      check("t7_rst_mcnt", 32'(mispred_cnt), 32'd0);
      check("t7_rst_rcnt", 32'(resolve_cnt), 32'd0);
      check("t7_rst_empty", 32'(empty), 32'd1);
      @(posedge clk); #1 arst_n = 1;

      // Counter saturation
      for (int i = 0; i < 9; i++) begin
         push(32'h200, 1'b1);
         pop(1'b1, 1'b0, 32'h300);
      end
      check("sat_rcnt", 32'(resolve_cnt), 32'd7);
      check("sat_mcnt0", 32'(mispred_cnt), 32'd0);
      for (int i = 0; i < 9; i++) begin
         push(32'h200, 1'b0);
         pop(1'b1, 1'b0, 32'h300);
      end
      check("sat_mcnt", 32'(mispred_cnt), 32'd7);
      check("sat_redirect", redirect_pc, 32'h300);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks in-flight predicted branches between fetch and execute.
- Fetch pushes each branch's PC and the predictor's prediction.
- Execute pops the oldest entry on resolution and compares outcome against prediction.
- Produces the registered update stream for the branch history table (write address, taken/jumped) plus a mispredict flush/redirect to fetch.

Parameters:
- PC_W, 32, program counter width.
- LOWER, 7, PC low bits forwarded as the history table write address.
- DEPTH, 4, queue entries (power of two, ≥2).
- CNT_W, 16, width of saturating statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- push_valid  in  1  fetch issues a conditional branch or jump this cycle.
- push_pc  in  PC_W  PC of the pushed instruction.
- push_pred  in  1  prediction bit used at fetch (1 = taken).
- full  out  1  queue holds DEPTH entries (combinational from count).
- empty  out  1  queue holds 0 entries (combinational from count).
- res_valid  in  1  execute resolves the oldest in-flight branch/jump.
- res_taken  in  1  conditional branch resolved taken.
- res_jump  in  1  resolved instruction is an unconditional jump.
- res_target  in  PC_W  resolved target address.
- ext_flush  in  1  external pipeline flush; discards all entries.
- upd_valid  out  1  history table update strobe.
- upd_addr  out  LOWER  history table write address = PC[LOWER-1:0] of popped entry.
- upd_was_taken  out  1  res_taken of popped entry.
- upd_jumped  out  1  res_jump of popped entry.
- mispredict  out  1  one-cycle redirect pulse.
- redirect_pc  out  PC_W  fetch restart address.
- underflow_err  out  1  sticky: res_valid seen while empty.
- mispred_cnt  out  CNT_W  saturating mispredict counter.
- resolve_cnt  out  CNT_W  saturating resolution counter.

Behaviour:
- Reset (arst_n low, async): rd/wr pointers 0, count 0, upd_valid 0, upd_addr 0, upd_was_taken 0, upd_jumped 0, mispredict 0, redirect_pc 0, underflow_err 0, both counters 0. Deassertion takes effect at the next edge. Reset mid-operation drops all entries.
- Storage: circular buffer of {pc, pred}. Pointers wrap modulo DEPTH. count is 0..DEPTH.
- Push: accepted iff push_valid and (not full, or a pop occurs in the same cycle). A push while full with no pop is dropped, and count stays DEPTH.
- Pop: occurs iff res_valid and not empty.
- Simultaneous push+pop: count unchanged, both pointers advance. At count 1 the new entry becomes the oldest.
- Actual direction: actual = res_taken | res_jump.
- Mispredict conditions:
  - actual != pred, or
  - actual = 1 and res_target != pc + 4 is not checked; target mismatch is execute's concern.
- Redirect address: actual ? res_target : pc + 4, computed in PC_W bits with wrap.
- Outputs (registered, 1-cycle latency after the pop edge):
  - upd_valid = 1 for exactly one cycle per pop.
  - upd_addr / upd_was_taken / upd_jumped hold their values until the next pop.
  - mispredict = 1 for one cycle. redirect_pc is loaded only on mispredict.
- Flush on mispredict: at the same edge as the mispredicting pop, all younger entries are discarded and pointers/count reset to 0. A push in that cycle is dropped (wrong path).
- ext_flush: clears pointers and count and ignores same-cycle push. A same-cycle pop still produces its update and mispredict outputs.
- Underflow: res_valid while empty produces no update and sets underflow_err, which stays set until reset.
- Counters: resolve_cnt increments per pop; mispred_cnt increments per mispredict. Both saturate at all-ones.

Test Plan:
- Reset then push pc=0x40 pred=0, resolve taken target=0x80 → next cycle upd_valid=1, upd_addr=0x40, upd_was_taken=1, mispredict=1, redirect_pc=0x80, count=0, mispred_cnt=1.
- Push pc=0x10, 0x14, 0x18, 0x1C (pred=1) → full=1. Fifth push dropped. Resolve four taken → addrs 0x10, 0x14, 0x18, 0x1C in order, no mispredict, resolve_cnt=4.
- Full queue with push+pop in the same cycle, correct prediction → count stays 4, new entry resolves last.
- Queue holds 3 entries, oldest pred=1 resolves not-taken pc=0x20 → redirect_pc=0x24, empty=1 after the edge, same-cycle push ignored.
- res_valid on empty → no upd_valid, underflow_err=1 and stays 1 through subsequent traffic until arst_n pulse.
- Jump (res_jump=1, res_taken=0) pred=0 pc=0x30 target=0x00 → upd_jumped=1, mispredict=1, redirect_pc=0x00. Then assert arst_n low mid-queue → all outputs 0 immediately.
